video_pattern_engine: RTL and testbench

- Parametrised pixel-domain test-pattern source; successor to the fixed gradient generator that fed the DVI encoder.
- Consumes timing from VideoFormatTiming (dataEnable, hSync, vSync, hPos, vPos).
- Produces RGB plus matched, delayed syncs for DviEncoder.
- Adds runtime-selectable patterns, frame-synchronous mode switching, a frame counter and an animated bouncing box.

---
 rtl/video_pattern_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_video_pattern_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_engine.sv
// Two-stage pixel-domain test-pattern source with frame-synchronous pattern switching,
// frame counter and bouncing box; syncs and data-enable are delayed to match the colour path.
module video_pattern_engine #(
    parameter int H_ACTIVE       = 1280,
    parameter int V_ACTIVE       = 720,
    parameter int HPOS_WIDTH     = 12,
    parameter int VPOS_WIDTH     = 11,
    parameter int COLOR_WIDTH    = 8,
    parameter int GRADIENT_SHIFT = 2,
    parameter int CHECKER_LOG2   = 5,
    parameter int BOX_SIZE       = 64,
    parameter int BOX_STEP       = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 patternSelect,
    input  logic [3*COLOR_WIDTH-1:0]   solidColor,
    input  logic                       dataEnableIn,
    input  logic                       hSyncIn,
    input  logic                       vSyncIn,
    input  logic [HPOS_WIDTH-1:0]      hPosIn,
    input  logic [VPOS_WIDTH-1:0]      vPosIn,
    output logic                       dataEnableOut,
    output logic                       hSyncOut,
    output logic                       vSyncOut,
    output logic [COLOR_WIDTH-1:0]     red,
    output logic [COLOR_WIDTH-1:0]     green,
    output logic [COLOR_WIDTH-1:0]     blue,
    output logic [2:0]                 patternActive,
    output logic [7:0]                 frameCount
);

    localparam int BAR_WIDTH = H_ACTIVE / 8;
    localparam logic [HPOS_WIDTH:0] X_MAX  = (HPOS_WIDTH+1)'(H_ACTIVE - BOX_SIZE);
    localparam logic [HPOS_WIDTH:0] X_STEP = (HPOS_WIDTH+1)'(BOX_STEP);
    localparam logic [HPOS_WIDTH:0] X_SIZE = (HPOS_WIDTH+1)'(BOX_SIZE);
    localparam logic [VPOS_WIDTH:0] Y_MAX  = (VPOS_WIDTH+1)'(V_ACTIVE - BOX_SIZE);
    localparam logic [VPOS_WIDTH:0] Y_STEP = (VPOS_WIDTH+1)'(BOX_STEP);
    localparam logic [VPOS_WIDTH:0] Y_SIZE = (VPOS_WIDTH+1)'(BOX_SIZE);
    localparam logic [COLOR_WIDTH-1:0] MAX = '1;

    localparam logic [2:0] PAT_SOLID    = 3'd0;
    localparam logic [2:0] PAT_BARS     = 3'd1;
    localparam logic [2:0] PAT_GRADIENT = 3'd2;
    localparam logic [2:0] PAT_CHECKER  = 3'd3;
    localparam logic [2:0] PAT_ANIMATED = 3'd4;
    localparam logic [2:0] PAT_BOX      = 3'd5;

    // Frame state
    logic                  frame_start;
    logic                  vsync_prev_q, vsync_prev_d;
    logic [2:0]            pattern_active_q, pattern_active_d;
    logic [7:0]            frame_count_q, frame_count_d;
    logic [HPOS_WIDTH:0]   box_x_q, box_x_d;
    logic [VPOS_WIDTH:0]   box_y_q, box_y_d;
    logic                  dir_x_q, dir_x_d;   // 1 = moving toward 0
    logic                  dir_y_q, dir_y_d;

    // Stage 1
    logic                     s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [2:0]               s1_bar_q, s1_bar_d;
    logic                     s1_checker_q, s1_checker_d, s1_in_box_q, s1_in_box_d;
    logic [COLOR_WIDTH-1:0]   s1_grad_q, s1_grad_d, s1_hlo_q, s1_hlo_d, s1_vlo_q, s1_vlo_d;
    logic [3*COLOR_WIDTH-1:0] s1_solid_q, s1_solid_d;

    // Stage 2
    logic                   s2_de_q, s2_de_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
    logic [COLOR_WIDTH-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [2:0]             bar_rgb;

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        frame_start      = vSyncIn & ~vsync_prev_q;
        vsync_prev_d     = vSyncIn;
        pattern_active_d = pattern_active_q;
        frame_count_d    = frame_count_q;
        box_x_d          = box_x_q;
        box_y_d          = box_y_q;
        dir_x_d          = dir_x_q;
        dir_y_d          = dir_y_q;
        if (frame_start) begin
            pattern_active_d = patternSelect;
            frame_count_d    = frame_count_q + 8'd1;
            if (!dir_x_q) begin
                if (box_x_q + X_STEP > X_MAX) begin
                    box_x_d = X_MAX;
                    dir_x_d = 1'b1;
                end else begin
                    box_x_d = box_x_q + X_STEP;
                end
            end else if (box_x_q < X_STEP) begin
                box_x_d = '0;
                dir_x_d = 1'b0;
            end else begin
                box_x_d = box_x_q - X_STEP;
            end
            if (!dir_y_q) begin
                if (box_y_q + Y_STEP > Y_MAX) begin
                    box_y_d = Y_MAX;
                    dir_y_d = 1'b1;
                end else begin
                    box_y_d = box_y_q + Y_STEP;
                end
            end else if (box_y_q < Y_STEP) begin
                box_y_d = '0;
                dir_y_d = 1'b0;
            end else begin
                box_y_d = box_y_q - Y_STEP;
            end
        end
    end

    always_comb begin
        s1_de_d    = dataEnableIn;
        s1_hs_d    = hSyncIn;
        s1_vs_d    = vSyncIn;
        s1_solid_d = solidColor;
        s1_grad_d  = COLOR_WIDTH'(hPosIn >> GRADIENT_SHIFT);
        s1_hlo_d   = COLOR_WIDTH'(hPosIn);
        s1_vlo_d   = COLOR_WIDTH'(vPosIn);
        s1_checker_d = hPosIn[CHECKER_LOG2] ^ vPosIn[CHECKER_LOG2];
        s1_in_box_d  = ({1'b0, hPosIn} >= box_x_q) && ({1'b0, hPosIn} < box_x_q + X_SIZE) &&
                       ({1'b0, vPosIn} >= box_y_q) && ({1'b0, vPosIn} < box_y_q + Y_SIZE);
        // Bar index from constant thresholds; columns past the last bar stay black.
        s1_bar_d = '0;
        for (int k = 1; k < 8; k++) begin
            if (hPosIn >= HPOS_WIDTH'(k * BAR_WIDTH)) s1_bar_d = 3'(k);
        end
    end

    always_comb begin
        s2_de_d = s1_de_q;
        s2_hs_d = s1_hs_q;
        s2_vs_d = s1_vs_q;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        unique case (s1_bar_q)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        if (s1_de_q) begin
            case (pattern_active_q)
                PAT_SOLID:    {red_d, green_d, blue_d} = s1_solid_q;
                PAT_BARS: begin
                    red_d   = {COLOR_WIDTH{bar_rgb[2]}};
                    green_d = {COLOR_WIDTH{bar_rgb[1]}};
                    blue_d  = {COLOR_WIDTH{bar_rgb[0]}};
                end
                PAT_GRADIENT: {red_d, green_d, blue_d} = {3{s1_grad_q}};
                PAT_CHECKER:  {red_d, green_d, blue_d} = {3{s1_checker_q ? MAX : '0}};
                PAT_ANIMATED: begin
                    red_d   = s1_hlo_q;
                    green_d = s1_vlo_q;
                    blue_d  = COLOR_WIDTH'(frame_count_q);
                end
                PAT_BOX: begin
                    red_d   = s1_in_box_q ? MAX : '0;
                    green_d = s1_in_box_q ? MAX : '0;
                    blue_d  = MAX;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the pipeline is async-reset too, so outputs drop to 0 the instant reset asserts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_prev_q     <= 1'b0;
            pattern_active_q <= '0;
            frame_count_q    <= '0;
            box_x_q          <= '0;
            box_y_q          <= '0;
            dir_x_q          <= 1'b0;
            dir_y_q          <= 1'b0;
            s1_de_q          <= 1'b0;
            s1_hs_q          <= 1'b0;
            s1_vs_q          <= 1'b0;
            s1_bar_q         <= '0;
            s1_checker_q     <= 1'b0;
            s1_in_box_q      <= 1'b0;
            s1_grad_q        <= '0;
            s1_hlo_q         <= '0;
            s1_vlo_q         <= '0;
            s1_solid_q       <= '0;
            s2_de_q          <= 1'b0;
            s2_hs_q          <= 1'b0;
            s2_vs_q          <= 1'b0;
            red_q            <= '0;
            green_q          <= '0;
            blue_q           <= '0;
        end else begin
            vsync_prev_q     <= vsync_prev_d;
            pattern_active_q <= pattern_active_d;
            frame_count_q    <= frame_count_d;
            box_x_q          <= box_x_d;
            box_y_q          <= box_y_d;
            dir_x_q          <= dir_x_d;
            dir_y_q          <= dir_y_d;
            s1_de_q          <= s1_de_d;
            s1_hs_q          <= s1_hs_d;
            s1_vs_q          <= s1_vs_d;
            s1_bar_q         <= s1_bar_d;
            s1_checker_q     <= s1_checker_d;
            s1_in_box_q      <= s1_in_box_d;
            s1_grad_q        <= s1_grad_d;
            s1_hlo_q         <= s1_hlo_d;
            s1_vlo_q         <= s1_vlo_d;
            s1_solid_q       <= s1_solid_d;
            s2_de_q          <= s2_de_d;
            s2_hs_q          <= s2_hs_d;
            s2_vs_q          <= s2_vs_d;
            red_q            <= red_d;
            green_q          <= green_d;
            blue_q           <= blue_d;
        end
    end

    assign dataEnableOut = s2_de_q;
    assign hSyncOut      = s2_hs_q;
    assign vSyncOut      = s2_vs_q;
    assign red           = red_q;
    assign green         = green_q;
    assign blue          = blue_q;
    assign patternActive = pattern_active_q;
    assign frameCount    = frame_count_q;

endmodule

// File: tb/tb_video_pattern_engine.sv
// Self-checking bench for video_pattern_engine: directed pattern/boundary cases plus random
// pixels, scored against a frame-level reference model with a two-deep expectation queue.
module tb_video_pattern_engine;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int BOX      = 64;
    localparam int STEP     = 4;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  patternSelect;
    logic [23:0] solidColor;
    logic        dataEnableIn, hSyncIn, vSyncIn;
    logic [11:0] hPosIn;
    logic [10:0] vPosIn;
    logic        dataEnableOut, hSyncOut, vSyncOut;
    logic [7:0]  red, green, blue;
    logic [2:0]  patternActive;
    logic [7:0]  frameCount;

    video_pattern_engine dut (
        .clock(clock), .reset(reset), .patternSelect(patternSelect), .solidColor(solidColor),
        .dataEnableIn(dataEnableIn), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
        .hPosIn(hPosIn), .vPosIn(vPosIn),
        .dataEnableOut(dataEnableOut), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut),
        .red(red), .green(green), .blue(blue),
        .patternActive(patternActive), .frameCount(frameCount)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model state, advanced one whole frame at a time
    int m_pat, m_fc, m_bx, m_by, m_dx, m_dy;
    bit prev_vs;
    logic [2:0]  sel;
    logic [23:0] sc;

    typedef struct {
        logic        de, hs, vs;
        logic [23:0] rgb;
    } exp_t;
    exp_t pipe[$];

    task automatic model_reset();
        m_pat = 0; m_fc = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
        prev_vs = 1'b0;
        pipe.delete();
    endtask

    task automatic move(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + STEP > lim - BOX) begin p = lim - BOX; d = -1; end
            else p = p + STEP;
        end else begin
            if (p < STEP) begin p = 0; d = 1; end
            else p = p - STEP;
        end
    endtask

    function automatic logic [23:0] model_rgb(int pat, int h, int v, bit de, logic [23:0] solid, int fc);
        int bar;
        if (!de) return 24'h0;
        case (pat)
            0: return solid;
            1: begin
                bar = h / (H_ACTIVE / 8);
                return BARS[(bar > 7) ? 7 : bar];
            end
            2: return {3{8'(h / 4)}};
            3: return (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            4: return {8'(h), 8'(v), 8'(fc)};
            5: return (h >= m_bx && h < m_bx + BOX && v >= m_by && v < m_by + BOX) ? 24'hFFFFFF : 24'h0000FF;
            default: return 24'h0;
        endcase
    endfunction

    // One pixel clock: score outputs of the pixel driven two cycles ago, then drive a new one.
    task automatic step(input bit de, input bit hs, input bit vs, input int h, input int v);
        exp_t e;
        @(negedge clock);
        check("frameCount", frameCount, m_fc);
        check("patternActive", patternActive, m_pat);
        if (pipe.size() == 2) begin
            e = pipe.pop_front();
            check("dataEnableOut", dataEnableOut, e.de);
            check("hSyncOut", hSyncOut, e.hs);
            check("vSyncOut", vSyncOut, e.vs);
            check("rgb", {red, green, blue}, e.rgb);
        end
        patternSelect = sel;
        solidColor    = sc;
        dataEnableIn  = de;
        hSyncIn       = hs;
        vSyncIn       = vs;
        hPosIn        = 12'(h);
        vPosIn        = 11'(v);
        e.de  = de;
        e.hs  = hs;
        e.vs  = vs;
        e.rgb = model_rgb(m_pat, h, v, de, sc, m_fc);
        if (vs && !prev_vs) begin
            m_pat = sel;
            m_fc  = (m_fc + 1) % 256;
            move(m_bx, m_dx, H_ACTIVE);
            move(m_by, m_dy, V_ACTIVE);
        end
        prev_vs = vs;
        pipe.push_back(e);
    endtask

    task automatic frame(input int hold);
        for (int i = 0; i < hold; i++) step(1'b0, 1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pix(input int h, input int v);
        step(1'b1, 1'($urandom_range(1)), 1'b0, h, v);
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset_release();
        dataEnableIn = 1'b0; hSyncIn = 1'b0; vSyncIn = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        sel = 3'd0; sc = 24'h0;
        patternSelect = 3'd0; solidColor = 24'h0;
        dataEnableIn = 1'b0; hSyncIn = 1'b0; vSyncIn = 1'b0; hPosIn = '0; vPosIn = '0;
        do_reset_release();

        // Reset state, then first boundary with solid colour
        step(1'b0, 1'b0, 1'b0, 0, 0);
        sc = 24'h3C5AA5;
        frame(1);
        for (int i = 0; i < 4; i++) pix($urandom_range(1279), $urandom_range(719));

        // Colour bars, including the first/last column of the first bar and the far edge
        sel = 3'd1;
        frame(2);
        pix(0, 10); pix(159, 10); pix(160, 10); pix(1279, 10);
        for (int b = 0; b < 8; b++) pix(b * 160 + 80, 20);
        step(1'b0, 1'b1, 1'b0, 0, 0);

        // Request checkerboard mid-frame: bars must persist until the next boundary
        sel = 3'd3;
        pix(0, 300); pix(170, 300); pix(1279, 300);
        frame(1);
        pix(0, 0); pix(32, 0); pix(32, 32); pix(0, 32); pix(95, 64);

        // Gradient wrap, then the same columns blanked while syncs keep moving
        sel = 3'd2;
        frame(1);
        pix(1023, 5); pix(1024, 5);
        step(1'b0, 1'b1, 1'b0, 1023, 5);
        step(1'b0, 1'b1, 1'b1, 1024, 5);
        step(1'b0, 1'b0, 1'b0, 1024, 5);

        // Async reset mid-line with random inputs; outputs must be zero at once
        sel = 3'd1;
        frame(1);
        pix(0, 1); pix(1, 1);
        @(negedge clock);
        dataEnableIn = 1'b1; hSyncIn = 1'($urandom); vSyncIn = 1'($urandom);
        hPosIn = 12'($urandom); vPosIn = 11'($urandom); patternSelect = 3'($urandom);
        #2 reset = 1'b1;
        #1;
        check("rst_rgb", {red, green, blue}, 24'h0);
        check("rst_syncs", {dataEnableOut, hSyncOut, vSyncOut}, 3'b000);
        check("rst_patternActive", patternActive, 3'd0);
        check("rst_frameCount", frameCount, 8'd0);
        do_reset_release();
        step(1'b0, 1'b0, 1'b0, 0, 0);

        // Bouncing box from reset through the X reversal; box edges probed each frame
        sel = 3'd5;
        for (int f = 0; f < 310; f++) begin
            frame(1 + (f % 3));
            pix(m_bx, m_by);
            if (m_bx > 0) pix(m_bx - 1, m_by);
            pix(m_bx + BOX - 1, m_by + BOX - 1);
            pix(m_bx + BOX, m_by);
            pix(m_bx, m_by + BOX);
        end

        // Animated pattern at a known frame count; loop is bounded by one wrap
        sel = 3'd4;
        for (int f = 0; f < 300 && m_fc != 8'h56; f++) frame(1);
        check("fc_reached_56", frameCount, 8'h56);
        pix(8'h12, 8'h34);
        pix(300, 700);

        // Random frames with mid-frame select changes and out-of-range positions
        for (int f = 0; f < 60; f++) begin
            sel = 3'($urandom);
            sc  = 24'($urandom);
            frame(1 + $urandom_range(2));
            for (int i = 0; i < 20; i++) begin
                if (i == 10) sel = 3'($urandom);
                if ($urandom_range(3) == 0)
                    step(1'b0, 1'($urandom_range(1)), 1'b0, $urandom_range(1400), $urandom_range(800));
                else
                    pix($urandom_range(1400), $urandom_range(800));
            end
        end
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
